// File: rtl/rou_master_if.sv
// Roubus bus-master endpoint: turns one local read/write request into a ring request
// message, waits for the tagged response (or a timeout) and reports completion.
module rou_master_if #(
  parameter int DWID = 128,
  parameter int AWID = 32,
  parameter int CWID = 8,
  parameter int WID  = 2 + DWID + AWID + CWID,
  parameter int TMO  = 1023
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_wr,
  input  logic            req_rd,
  input  logic [AWID-1:0] req_addr,
  input  logic [DWID-1:0] req_wdata,
  output logic            req_busy,
  output logic            rsp_valid,
  output logic            rsp_error,
  output logic [DWID-1:0] rsp_rdata,
  output logic [15:0]     stale_cnt,
  output logic [WID-1:0]  msg_out,
  input  logic            msg_out_ack,
  input  logic [WID-1:0]  msg_in,
  output logic            msg_in_ack
);

  localparam int TW   = $clog2(TMO + 1);
  localparam int TAGW = CWID - 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TMO - 1);
  localparam logic [TW-1:0]   TMR_ONE  = TW'(1);
  localparam logic [TAGW-1:0] TAG_ONE  = TAGW'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  logic [WID-1:0]    r_msg_out;
  logic              r_msg_in_ack;
  logic              r_rsp_valid;
  logic              r_rsp_error;
  logic [DWID-1:0]   r_rsp_rdata;
  logic [15:0]       r_stale_cnt;
  logic [TAGW-1:0]   r_tag;
  logic [TW-1:0]     r_timer;
  logic              r_is_rd;
  logic              r_cap_err;
  logic [DWID-1:0]   r_cap_rdata;

  logic [1:0]        w_in_cmd;
  logic [CWID-1:0]   w_in_ctrl;
  logic [DWID-1:0]   w_in_data;
  logic [AWID-1:0]   w_unused_in_addr;
  logic              w_in_present;
  logic              w_in_match;
  logic              w_timeout;

  assign w_in_cmd         = msg_in[WID-1 -: 2];
  assign w_in_ctrl        = msg_in[WID-3 -: CWID];
  assign w_unused_in_addr = msg_in[DWID +: AWID];
  assign w_in_data        = msg_in[DWID-1:0];

  // A message whose ack is already registered is consumed at the coming edge,
  // so it is not looked at a second time.
  assign w_in_present = (w_in_cmd != 2'b00) && !r_msg_in_ack;
  assign w_in_match   = (r_state == S_WAIT) && (w_in_cmd == 2'b11) &&
                        (w_in_ctrl[TAGW-1:0] == r_tag) && w_in_present;
  assign w_timeout    = (r_timer == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_msg_out    <= '0;
      r_msg_in_ack <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_error  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_stale_cnt  <= '0;
      r_tag        <= '0;
      r_timer      <= '0;
      r_is_rd      <= 1'b0;
      r_cap_err    <= 1'b0;
      r_cap_rdata  <= '0;
    end else begin
      r_msg_in_ack <= w_in_present;
      if (w_in_present && !w_in_match && (r_stale_cnt != 16'hFFFF))
        r_stale_cnt <= r_stale_cnt + 16'd1;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (req_wr) begin
            r_msg_out <= {2'b01, 1'b0, r_tag, req_addr, req_wdata};
            r_is_rd   <= 1'b0;
            r_state   <= S_SEND;
          end else if (req_rd) begin
            r_msg_out <= {2'b10, 1'b0, r_tag, req_addr, {DWID{1'b0}}};
            r_is_rd   <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (msg_out_ack) begin
            r_msg_out <= '0;
            r_timer   <= '0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_timer <= r_timer + TMR_ONE;
          // A match on the final timer cycle takes precedence over the timeout.
          if (w_in_match) begin
            r_cap_err   <= w_in_ctrl[CWID-1];
            r_cap_rdata <= r_is_rd ? w_in_data : '0;
            r_state     <= S_DONE;
          end else if (w_timeout) begin
            r_cap_err   <= 1'b1;
            r_cap_rdata <= '0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_rsp_valid <= 1'b1;
          r_rsp_error <= r_cap_err;
          r_rsp_rdata <= r_cap_rdata;
          r_tag       <= r_tag + TAG_ONE;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_busy   = (r_state != S_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_error  = r_rsp_error;
  assign rsp_rdata  = r_rsp_rdata;
  assign stale_cnt  = r_stale_cnt;
  assign msg_out    = r_msg_out;
  assign msg_in_ack = r_msg_in_ack;

endmodule

// File: doc/rou_master_if.md
Name: rou_master_if

Overview:
- Bus-master endpoint that turns single local read/write requests into roubus request messages.
- Drives them onto the ring toward the memory-interface stage, then waits for the matching response message and returns data/status to the local requester.
- Sits directly upstream of the ring memory interface: its msg_out feeds that stage's msg_in, and its msg_in consumes that stage's msg_out.
- One transaction outstanding at a time; responses are protected by a tag and a timeout.

Parameters:
- DWID, 128, data field width
- AWID, 32, address field width
- CWID, 8, control field width (bit CWID-1 = error flag, bits CWID-2:0 = tag)
- WID, 2+DWID+AWID+CWID, message width
- TMO, 1023, response timeout in cycles, minimum 2

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_wr  input  1  write request pulse, sampled only in IDLE
- req_rd  input  1  read request pulse, sampled only in IDLE
- req_addr  input  AWID  request address
- req_wdata  input  DWID  write data
- req_busy  output  1  high whenever state is not IDLE
- rsp_valid  output  1  one-cycle completion pulse
- rsp_error  output  1  valid with rsp_valid; error flag or timeout
- rsp_rdata  output  DWID  read data, valid with rsp_valid; 0 for writes/timeouts
- stale_cnt  output  16  count of dropped non-matching responses, saturating
- msg_out  output  WID  request message to ring
- msg_out_ack  input  1  ring consumed msg_out this cycle
- msg_in  input  WID  response message from ring
- msg_in_ack  output  1  this block consumed msg_in this cycle

Behaviour:
- Message layout, MSB down: cmd[1:0], ctrl[CWID-1:0], addr[AWID-1:0], data[DWID-1:0].
- cmd encoding: 00 = empty, 01 = write, 10 = read, 11 = response. A message is present iff cmd != 00.
- Reset (async, rst_n low): state IDLE; msg_out = 0; msg_in_ack = 0; rsp_valid = 0; rsp_error = 0; rsp_rdata = 0; stale_cnt = 0; tag = 0; timer = 0. Reset mid-transaction abandons it silently with no rsp_valid.
- State IDLE:
  - req_wr has priority if both are high; req_rd is ignored that cycle.
  - On a request: register msg_out = {cmd, 1'b0, tag, req_addr, data}. data = req_wdata for writes, 0 for reads.
  - Go to SEND. msg_out is valid the cycle after the request.
- State SEND:
  - msg_out is held stable until msg_out_ack is sampled high.
  - On that edge: msg_out <= 0, timer <= 0, go to WAIT. No timeout applies in SEND.
- State WAIT:
  - timer increments every cycle.
  - If msg_in.cmd == 11 and msg_in.ctrl tag equals the current tag: assert msg_in_ack for one cycle, capture rdata and the error bit, go to DONE.
  - If msg_in.cmd != 00 and it does not match: assert msg_in_ack (drop it) and increment stale_cnt, saturating at 0xFFFF.
  - If timer reaches TMO with no match: go to DONE with rsp_error = 1 and rdata = 0. A match on the TMO cycle itself wins over the timeout.
- State DONE:
  - rsp_valid = 1 for exactly one cycle.
  - tag <= tag + 1, wrapping modulo 2^(CWID-1).
  - Return to IDLE; the next request can be accepted the following cycle.
- Outside WAIT:
  - Any msg_in with cmd != 00 is acked and counted as stale, so a late response after a timeout is drained.
  - msg_in_ack is registered and never high while msg_in.cmd == 00.
- Latency:
  - Request to msg_out valid: 1 cycle.
  - Matching response to rsp_valid: 2 cycles (ack cycle, then DONE).

Test Plan:
- Write: req_wr with addr 0x1000 and wdata 0xA5..A5, ack after 3 cycles, response cmd 11 tag 0 -> msg_out holds {01, 0x00, 0x1000, A5..} for 3 cycles; rsp_valid 2 cycles after the response with rsp_error 0.
- Read: req_rd with addr 0x20, response data 0xDEADBEEF and tag 1 -> rsp_rdata 0xDEADBEEF; the following transaction uses tag 2.
- Mismatch then match: response with tag 5 while waiting on tag 2, then tag 2 -> first acked and dropped with stale_cnt 1; second completes normally.
- Timeout: TMO=8, no response -> rsp_valid with rsp_error 1 about 9 cycles after the ack; a late response is acked and stale_cnt increments.
- Priority and tag wrap: req_wr and req_rd together -> write cmd issued. Run 128 transactions with CWID=8 -> tag wraps 127 to 0.
- Reset in WAIT: assert rst_n low -> all outputs 0 immediately; no rsp_valid after release; tag restarts at 0.
